dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the multicycle CPU: the memory side of the load/store path.
- Accepts load/store requests from the CPU datapath, applies a configurable access latency, performs byte, halfword or word access on an internal word-organised RAM, and returns load data.
- rdata feeds the CPU's data-register stage; the CPU samples it on the ack cycle.

Parameters:
ADDR_W, 8, word-address width; RAM depth is 2**ADDR_W 32-bit words.
LATENCY, 2, wait cycles between request acceptance and response; legal range 0..15.

Ports:
CLK  input  1  clock; all state changes on its rising edge.
RST_N  input  1  asynchronous active-low reset.
req  input  1  request strobe; sampled only in IDLE.
we  input  1  1 = store, 0 = load.
addr  input  32  byte address; bits [ADDR_W+1:2] select the word, bits [1:0] the byte lane, higher bits ignored (wrap).
size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
sext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
wdata  input  32  store data, right-justified.
busy  output  1  high from the acceptance edge until the edge after ack.
ack  output  1  one-cycle completion pulse.
err  output  1  pulses with ack when a request is misaligned or uses size 11.
rdata  output  32  load result; holds its value between load acks.

Behaviour:
- Reset (asynchronous, RST_N=0): state=IDLE, busy=0, ack=0, err=0, rdata=0, wait counter=0.
  - RAM contents are not reset.
  - Reset mid-operation abandons the request; any pending store is not performed.
- Reset release: the first edge with RST_N=1 may accept a request.
- States: IDLE, WAIT, RESP.
- IDLE, on an edge with req=1:
  - capture we, addr, size, sext and wdata into internal registers; the CPU may change its inputs afterwards;
  - set busy=1 and counter=LATENCY;
  - go to WAIT if LATENCY>0, otherwise go straight to the completion edge below.
  - With req=0, stay in IDLE.
- WAIT: decrement the counter each edge; the edge on which it reaches 0 is the completion edge.
- Completion edge (state becomes RESP, ack=1):
  - Aligned store: write the selected lanes.
    - Byte: lane addr[1:0] gets wdata[7:0].
    - Halfword: lanes {addr[1],0} and {addr[1],1} get wdata[15:0], little-endian (lower address = low byte).
    - Word: all four lanes get wdata.
    - rdata is unchanged.
  - Aligned load: rdata = selected byte or halfword, shifted to bits [7:0] or [15:0] and extended per sext; word loads return the whole word.
  - Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) or size=11: no RAM write, rdata unchanged, err=1.
- RESP, one cycle: next edge sets ack=0, err=0, busy=0 and returns to IDLE.
  - req on the RESP cycle is ignored; earliest re-acceptance is the following IDLE cycle.
- Latency: ack is high in cycle T+LATENCY+1 after acceptance at edge T. Back-to-back requests are spaced LATENCY+2 cycles apart.
- req while busy=1 is ignored and not queued.
- Read-after-write: a load of a just-stored address returns the new data, since the write commits before the next request is accepted.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enumeration;
  - function extracting and extending lane data from a word given addr[1:0], size and sext.
- One sub-module, dmem_ram: single-port synchronous word RAM with 4-bit byte-write enable and asynchronous read. The responder owns the FSM, alignment check and lane formatting.

Test Plan:
- Word store/load, LATENCY=2: store 0xDEADBEEF at 0x10 accepted at edge T -> ack and busy-falling as specified, ack high in cycle T+3; load 0x10 -> rdata=0xDEADBEEF on ack, err=0.
- Byte lanes:
  - store byte 0x80 at 0x13 over word 0x11223344 -> word reads 0x80223344;
  - load byte 0x13 with sext=1 -> 0xFFFFFF80; sext=0 -> 0x00000080.
- Halfword: store 0xA5A5 at 0x22 over 0 -> word 0xA5A50000; load half 0x22 with sext=1 -> 0xFFFFA5A5.
- Misaligned: word load at 0x11 -> ack and err together, rdata keeps its previous value; word store at 0x12 -> RAM unchanged (verified by a subsequent aligned load).
- Handshake edges:
  - req held high continuously -> accepts once per LATENCY+2 cycles, one ack each;
  - LATENCY=0 build -> ack in the cycle right after acceptance;
  - inputs changed after acceptance -> response uses the captured values.
- Reset mid-operation: assert RST_N=0 during WAIT of a store 0x12345678 to 0x40 -> outputs immediately 0, no ack; after release, load 0x40 returns the old contents.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared encodings and lane formatting for the data-memory responder.
// Combinational helpers only; no latency, no backpressure.
package dmem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Pull the addressed byte/halfword down to bit 0 and extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return {{24{sext & b[7]}}, b};
      SZ_HALF: return {{16{sext & h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised RAM, byte-lane write enables, write on clock edge.
// Read is asynchronous (same cycle); no backpressure.
module dmem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdat,
  output logic [31:0]       rdat
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdat[8*i +: 8];
    end
  end

  assign rdat = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: captures one request, waits LATENCY edges, then acks.
// Ack LATENCY edges after acceptance; req is ignored while busy (no queueing).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int AW = ADDR_W + 2;

  state_t         state, state_nx;
  logic [3:0]     cnt, cnt_nx;
  logic           busy_nx, ack_nx, err_nx;
  logic [31:0]    rdata_nx;
  logic           cap_ld, complete;

  logic           cap_we, cap_sext;
  logic [AW-1:0]  cap_addr;
  logic [1:0]     cap_size;
  logic [31:0]    cap_wdata;

  logic           from_in;
  logic           op_we, op_sext;
  logic [AW-1:0]  op_addr;
  logic [1:0]     op_size;
  logic [31:0]    op_wdata;

  logic           aligned;
  logic [3:0]     lane_be, ram_be;
  logic [31:0]    ram_wdat, ram_rdat;

  logic           unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW];

  // With LATENCY=0 the acceptance edge is also the completion edge, so the
  // operation comes straight from the inputs while still in IDLE.
  assign from_in  = (state == ST_IDLE);
  assign op_we    = from_in ? we              : cap_we;
  assign op_sext  = from_in ? sext            : cap_sext;
  assign op_addr  = from_in ? addr[AW-1:0]    : cap_addr;
  assign op_size  = from_in ? size            : cap_size;
  assign op_wdata = from_in ? wdata           : cap_wdata;

  always_comb begin
    aligned  = 1'b0;
    lane_be  = 4'b1111;
    ram_wdat = op_wdata;
    case (op_size)
      SZ_BYTE: begin
        aligned  = 1'b1;
        lane_be  = 4'b0001 << op_addr[1:0];
        ram_wdat = {4{op_wdata[7:0]}};
      end
      SZ_HALF: begin
        aligned  = ~op_addr[0];
        lane_be  = op_addr[1] ? 4'b1100 : 4'b0011;
        ram_wdat = {2{op_wdata[15:0]}};
      end
      SZ_WORD: aligned = (op_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign ram_be = (complete && op_we && aligned && RST_N) ? lane_be : 4'b0000;

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .CLK  (CLK),
    .addr (op_addr[AW-1:2]),
    .be   (ram_be),
    .wdat (ram_wdat),
    .rdat (ram_rdat)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy_nx  = busy;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    rdata_nx = rdata;
    cap_ld   = 1'b0;
    complete = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          cap_ld  = 1'b1;
          busy_nx = 1'b1;
          cnt_nx  = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_nx = ST_RESP;
            complete = 1'b1;
          end else begin
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = ST_RESP;
          complete = 1'b1;
        end
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (complete) begin
      ack_nx = 1'b1;
      err_nx = ~aligned;
      if (aligned && !op_we) rdata_nx = lane_extract(ram_rdat, op_addr[1:0], op_size, op_sext);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      cap_we    <= 1'b0;
      cap_sext  <= 1'b0;
      cap_addr  <= '0;
      cap_size  <= 2'b00;
      cap_wdata <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= busy_nx;
      ack   <= ack_nx;
      err   <= err_nx;
      rdata <= rdata_nx;
      if (cap_ld) begin
        cap_we    <= we;
        cap_sext  <= sext;
        cap_addr  <= addr[AW-1:0];
        cap_size  <= size;
        cap_wdata <= wdata;
      end
    end
  end

endmodule
